// File: rtl/uart_tx_word.sv
// Word-buffered UART transmitter: loads 32-bit words, sends bytes LE as 8N1.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_word #(
   parameter int DIV_RATE  = 16,
   parameter int MAX_WORDS = 4,
   parameter int WNUM_W    = 3
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [WNUM_W-1:0] word_number,
   input  logic              start,
   input  logic              word_valid,
   input  logic [31:0]       word_data,
   output logic              word_ready,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int NBYTES = 4 * MAX_WORDS;
   localparam int BI_W   = $clog2(NBYTES);
   localparam int NB_W   = WNUM_W + 3;
   localparam int CW     = (BI_W + 1 > NB_W) ? BI_W + 1 : NB_W;
   localparam int DW     = $clog2(DIV_RATE);

`ifdef UART_TX_PARITY_EN
   localparam logic [3:0] LAST_BIT = 4'd10;
`else
   localparam logic [3:0] LAST_BIT = 4'd9;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SEND,
      S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     limit_q, limit_d;
   logic [CW-1:0]     wcnt_q, wcnt_d;
   logic [DW-1:0]     div_q, div_d;
   logic [3:0]        bit_q, bit_d;
   logic [BI_W-1:0]   byte_q, byte_d;
   logic [7:0]        buf_q [NBYTES];

   logic [CW-1:0]     wn_ext;
   logic [CW-1:0]     clamp;
   logic [CW-1:0]     last_byte;
   logic [BI_W-1:0]   wbase;
   logic [7:0]        cur;
   logic              dbit;

   assign wn_ext    = CW'(word_number);
   assign clamp     = (wn_ext > CW'(MAX_WORDS)) ? CW'(MAX_WORDS) : wn_ext;
   assign last_byte = (limit_q << 2) - CW'(1);
   assign wbase     = BI_W'(wcnt_q << 2);
   assign cur       = buf_q[byte_q];
   assign dbit      = cur[3'(bit_q - 4'd1)];

   always_ff @(posedge clk) begin
      if (resetn) begin
         state_q <= S_IDLE;
         limit_q <= '0;
         wcnt_q  <= '0;
         div_q   <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
      end else begin
         state_q <= state_d;
         limit_q <= limit_d;
         wcnt_q  <= wcnt_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
      end
   end

   // Byte storage needs no reset; contents are only read after a fresh load.
   always_ff @(posedge clk) begin
      if (state_q == S_LOAD && word_valid) begin
         for (int j = 0; j < 4; j++) begin
            buf_q[wbase + BI_W'(j)] <= word_data[8*j +: 8];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      limit_d    = limit_q;
      wcnt_d     = wcnt_q;
      div_d      = div_q;
      bit_d      = bit_q;
      byte_d     = byte_q;
      word_ready = 1'b0;
      tx         = 1'b1;
      busy       = (state_q != S_IDLE);
      done       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start && word_number != '0) begin
               limit_d = clamp;
               wcnt_d  = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            word_ready = 1'b1;
            if (word_valid) begin
               wcnt_d = wcnt_q + CW'(1);
               if (wcnt_q == limit_q - CW'(1)) begin
                  state_d = S_SEND;
                  div_d   = DW'(DIV_RATE - 1);
                  bit_d   = '0;
                  byte_d  = '0;
               end
            end
         end
         S_SEND: begin
            if (bit_q == 4'd0) begin
               tx = 1'b0;
            end else if (bit_q <= 4'd8) begin
               tx = dbit;
`ifdef UART_TX_PARITY_EN
            end else if (bit_q == 4'd9) begin
               tx = ^cur;
`endif
            end else begin
               tx = 1'b1;
            end
            if (div_q == '0) begin
               div_d = DW'(DIV_RATE - 1);
               if (bit_q == LAST_BIT) begin
                  bit_d = '0;
                  if (CW'(byte_q) == last_byte) begin
                     state_d = S_DONE;
                  end else begin
                     byte_d = byte_q + BI_W'(1);
                  end
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end else begin
               div_d = div_q - DW'(1);
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_word.sv
// Directed bench for uart_tx_word: decodes serial frames and checks timing.
module tb_uart_tx_word;

   localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic [2:0]  word_number = '0;
   logic        start = 1'b0;
   logic        word_valid = 1'b0;
   logic [31:0] word_data = '0;
   logic        word_ready;
   logic        tx;
   logic        busy;
   logic        done;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] exp_b [16];

   uart_tx_word #(
      .DIV_RATE (DIV),
      .MAX_WORDS(4),
      .WNUM_W   (3)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .word_number(word_number),
      .start      (start),
      .word_valid (word_valid),
      .word_data  (word_data),
      .word_ready (word_ready),
      .tx         (tx),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic kick(input logic [2:0] wn);
      word_number = wn;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic push_word(input logic [31:0] d, input int gap);
      logic rdy;
      bit ok;
      ok = 0;
      repeat (gap) tick();
      word_data  = d;
      word_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         rdy = word_ready;
         tick();
         if (rdy) begin
            ok = 1;
            break;
         end
      end
      word_valid = 1'b0;
      if (!ok) chk("accept_timeout", 0, 1);
   endtask

   task automatic capture(input int nfr);
      logic [10:0] bits;
      logic [7:0]  d;
      logic        v;
      int          glitch;
      int          early;
      early = 0;
      bits  = '0;
      for (int f = 0; f < nfr; f++) begin
         glitch = 0;
         for (int b = 0; b < FB; b++) begin
            for (int k = 0; k < DIV; k++) begin
               v = tx;
               if (k == 0) bits[b] = v;
               else if (v !== bits[b]) glitch++;
               if (done) early++;
               tick();
            end
         end
         d = bits[8:1];
         chk("start_bit", bits[0], 0);
         chk("data_byte", d, exp_b[f]);
`ifdef UART_TX_PARITY_EN
         chk("parity_bit", bits[9], ^exp_b[f]);
`endif
         chk("stop_bit", bits[FB-1], 1);
         chk("bit_hold", glitch, 0);
      end
      chk("done_early", early, 0);
      chk("done_pulse", done, 1);
      chk("busy_in_done", busy, 1);
      chk("tx_in_done", tx, 1);
      tick();
      chk("done_clear", done, 0);
      chk("busy_idle", busy, 0);
   endtask

   initial begin
      int bad;
      // reset hold then idle watch
      repeat (3) tick();
      chk("rst_tx", tx, 1);
      chk("rst_ready", word_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      resetn = 1'b0;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         if (tx !== 1'b1 || word_ready !== 1'b0 ||
             busy !== 1'b0 || done !== 1'b0) bad++;
         tick();
      end
      chk("idle_quiet", bad, 0);

      // single word 0xA5
      kick(3'd1);
      chk("load_busy", busy, 1);
      chk("load_ready", word_ready, 1);
      push_word(32'h0000_00A5, 0);
      chk("send_ready_low", word_ready, 0);
      exp_b[0] = 8'hA5;
      exp_b[1] = 8'h00;
      exp_b[2] = 8'h00;
      exp_b[3] = 8'h00;
      capture(4);

      // two words with valid gaps
      kick(3'd2);
      push_word(32'h4433_2211, 3);
      chk("ready_after_w0", word_ready, 1);
      push_word(32'h8877_6655, 3);
      chk("ready_after_w1", word_ready, 0);
      for (int i = 0; i < 8; i++) exp_b[i] = 8'(8'h11 * (i + 1));
      capture(8);

      // zero-length start ignored
      kick(3'd0);
      repeat (5) tick();
      chk("wn0_busy", busy, 0);
      chk("wn0_ready", word_ready, 0);

      // clamp 7 -> 4 words
      kick(3'd7);
      for (int i = 0; i < 4; i++) begin
         push_word(32'h0302_0100 + 32'h0404_0404 * i, 0);
      end
      chk("clamp_ready_low", word_ready, 0);
      word_data  = 32'hDEAD_BEEF;
      word_valid = 1'b1;
      for (int i = 0; i < 16; i++) exp_b[i] = 8'(i);
      capture(16);
      chk("extra_not_taken", word_ready, 0);
      word_valid = 1'b0;

      // reset in byte 1, bit 3
      kick(3'd1);
      push_word(32'h0000_0055, 0);
      repeat (FB * DIV + 3 * DIV + 1) tick();
      chk("mid_tx_low", tx, 0);
      resetn = 1'b1;
      tick();
      chk("abort_tx", tx, 1);
      chk("abort_busy", busy, 0);
      chk("abort_ready", word_ready, 0);
      chk("abort_done", done, 0);
      resetn = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (done !== 1'b0 || busy !== 1'b0) bad++;
         tick();
      end
      chk("abort_quiet", bad, 0);
      kick(3'd1);
      push_word(32'h5A3C_0FF0, 0);
      exp_b[0] = 8'hF0;
      exp_b[1] = 8'h0F;
      exp_b[2] = 8'h3C;
      exp_b[3] = 8'h5A;
      capture(4);

`ifdef UART_TX_PARITY_EN
      kick(3'd1);
      push_word(32'h0000_0307, 0);
      exp_b[0] = 8'h07;
      exp_b[1] = 8'h03;
      exp_b[2] = 8'h00;
      exp_b[3] = 8'h00;
      capture(4);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
